// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply/divide unit: shift-add multiplier and restoring divider,
// one iteration per clock, full HI/LO result presented with a one-cycle done pulse.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       option,
  input  logic [WIDTH-1:0] oprd1,
  input  logic [WIDTH-1:0] oprd2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     mul_add;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_neg;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] iter_next;

  // One iteration of each algorithm. Multiply: acc holds the partial product, shifted right
  // while opb supplies multiplier bits. Divide: acc = {remainder, quotient}, opa shifts the
  // dividend out MSB first; the extra diff bit acts as the trial-subtract sign.
  always_comb begin
    mul_add   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opb_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_add, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    div_neg   = div_diff[WIDTH+1];
    div_rem   = div_neg ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], ~div_neg};
    iter_next = is_div_q ? div_next : mul_next;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start && ((option == OP_MUL) || (option == OP_DIV))) begin
          state_d  = S_RUN;
          is_div_d = (option == OP_DIV);
          opa_d    = oprd1;
          opb_d    = oprd2;
          cnt_d    = CW'(WIDTH);
          acc_d    = '0;
        end
      end
      S_RUN: begin
        acc_d = iter_next;
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          opa_d = {opa_q[WIDTH-2:0], 1'b0};
        end else begin
          opb_d = {1'b0, opb_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          hi_d    = iter_next[2*WIDTH-1:WIDTH];
          lo_d    = iter_next[WIDTH-1:0];
          // opb is never shifted in divide mode, so it still holds the divisor here
          dz_d    = is_div_q && (opb_q == '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign result   = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, products, quotients,
// divide-by-zero, ignored starts and mid-operation reset.
module tb_muldiv_unit;

  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  option;
  logic [31:0] oprd1;
  logic [31:0] oprd2;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] result;
  logic        div_zero;

  int checks   = 0;
  int failures = 0;
  int n_edges;
  int n_done;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .option(option),
    .oprd1(oprd1), .oprd2(oprd2), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .result(result), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a start request; returns #1 after the accepting edge E0 with junk on the operands.
  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; option = op; oprd1 = a; oprd2 = b;
    @(posedge clk); #1;
    start = 1'b0; option = 4'b0000; oprd1 = 32'hDEAD_BEEF; oprd2 = 32'h1234_5678;
  endtask

  // Counts edges after E0 until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz);
    int n;
    launch(op, a, b);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    wait_done(n);
    chk({tag, "_latency"}, 64'(n), 64'd32);
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    chk({tag, "_result"}, {32'd0, result}, {32'd0, exp_lo});
    chk({tag, "_dz"}, {63'd0, div_zero}, {63'd0, exp_dz});
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; option = 4'b0000; oprd1 = 32'd0; oprd2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_dz", {63'd0, div_zero}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("mul7x6", OP_MUL, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0);
    run_op("mulmax", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mulmsb", OP_MUL, 32'h8000_0000, 32'd2, 32'd1, 32'd0, 1'b0);
    run_op("div100_7", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div5_9", OP_DIV, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0);
    run_op("div5_0", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op("mul3x3", OP_MUL, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0);

    // Unsupported option: unit stays idle and results hold 3*3
    launch(4'b0010, 32'd11, 32'd13);
    chk("badop_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("badop_busy_later", {63'd0, busy}, 64'd0);
    chk("badop_hold", {hi, lo}, {32'd0, 32'd9});

    // Second start mid-run is neither taken nor queued
    launch(OP_MUL, 32'd7, 32'd6);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; option = OP_DIV; oprd1 = 32'd100; oprd2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n_edges);
    chk("midstart_latency", 64'(n_edges + 6), 64'd32);
    chk("midstart_res", {hi, lo}, {32'd0, 32'd42});
    n_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    chk("midstart_no_second", 64'(n_done), 64'd0);

    // Reset ten cycles into a divide aborts it
    launch(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    n_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    chk("abort_no_done", 64'(n_done), 64'd0);

    // Reset and start on the same edge: reset wins
    reset = 1'b1;
    launch(OP_MUL, 32'd2, 32'd2);
    reset = 1'b0;
    chk("rst_start_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    chk("rst_start_busy2", {63'd0, busy}, 64'd0);

    run_op("div_after_abort", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
